// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_param
//  Description : Parameterised oversampling UART receiver. rxd is brought
//                into the clk domain by a 2-flop synchronizer. Each bit is
//                resolved by a 2-of-3 majority vote of the samples taken at
//                oversample ticks OVS/2-1, OVS/2 and OVS/2+1. baud_div,
//                parity_mode and stop2 are latched when the start edge is
//                seen, so changes to them mid-frame do not affect that frame.
//  Optional    : UART_RX_PARITY_EN - when defined, the parity bit is received
//                and checked according to parity_mode. When undefined,
//                parity_mode is ignored, no parity state exists and
//                parity_err is tied to 0.
//  Ports       : clk         - system clock, rising edge
//                rst_n       - asynchronous active-low reset
//                rxd         - serial input, idle high, asynchronous to clk
//                baud_div    - oversample tick period minus 1, in clk cycles
//                parity_mode - 00 none, 01 odd, 10 even, 11 none
//                stop2       - 1: two stop bits, 0: one stop bit
//                rx_data     - last received word (LSB first on the line)
//                rx_valid    - one-cycle pulse when rx_data and flags update
//                parity_err  - parity mismatch on the flagged frame
//                frame_err   - a stop bit resolved to 0 on the flagged frame
//                busy        - high while a frame is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int DATA_W = 8,
    parameter int OVS    = 16,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxd,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int C_SAMP_W = $clog2(OVS);
    localparam int C_BIT_W  = $clog2(DATA_W);
    localparam logic [C_SAMP_W-1:0] C_IDX_A    = C_SAMP_W'(OVS / 2 - 1);
    localparam logic [C_SAMP_W-1:0] C_IDX_B    = C_SAMP_W'(OVS / 2);
    localparam logic [C_SAMP_W-1:0] C_IDX_C    = C_SAMP_W'(OVS / 2 + 1);
    localparam logic [C_SAMP_W-1:0] C_IDX_LAST = C_SAMP_W'(OVS - 1);
    localparam logic [C_BIT_W-1:0]  C_BIT_LAST = C_BIT_W'(DATA_W - 1);
    localparam logic [C_BIT_W-1:0]  C_BIT_ONE  = C_BIT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q, prev_q;
    logic [DIV_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [C_SAMP_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [C_BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                s0_q, s0_d, s1_q, s1_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                stop2_q, stop2_d;
    logic                ferr_acc_q, ferr_acc_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;

    logic w_tick, w_resolve, w_wrap, w_maj, w_perr;

    // Tick counter only runs outside IDLE, so w_tick is gated by state.
    assign w_tick    = (state_q != S_IDLE) && (tick_cnt_q == div_q);
    assign w_resolve = w_tick && (samp_cnt_q == C_IDX_C);
    assign w_wrap    = w_tick && (samp_cnt_q == C_IDX_LAST);
    // Third vote is the live synchronized sample at tick OVS/2+1.
    assign w_maj     = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);

`ifdef UART_RX_PARITY_EN
    logic [1:0] pmode_q, pmode_d;
    logic       pbit_q, pbit_d;
    logic       w_par_en, w_par_sum;

    assign w_par_en  = (pmode_q == 2'b01) || (pmode_q == 2'b10);
    assign w_par_sum = (^shift_q) ^ pbit_q;
    // Even mode expects an even count of ones (sum 0), odd mode an odd count.
    assign w_perr    = (pmode_q == 2'b10) ? w_par_sum :
                       (pmode_q == 2'b01) ? ~w_par_sum : 1'b0;
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
    assign w_perr             = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = w_tick ? '0 : tick_cnt_q + DIV_W'(1);
        samp_cnt_d = samp_cnt_q;
        if (w_tick) begin
            samp_cnt_d = w_wrap ? '0 : samp_cnt_q + C_SAMP_W'(1);
        end
        bit_cnt_d  = bit_cnt_q;
        s0_d       = (w_tick && samp_cnt_q == C_IDX_A) ? sync2_q : s0_q;
        s1_d       = (w_tick && samp_cnt_q == C_IDX_B) ? sync2_q : s1_q;
        shift_d    = shift_q;
        div_d      = div_q;
        stop2_d    = stop2_q;
        ferr_acc_d = ferr_acc_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
`ifdef UART_RX_PARITY_EN
        pmode_d    = pmode_q;
        pbit_d     = pbit_q;
`endif
        case (state_q)
            S_IDLE: begin
                tick_cnt_d = '0;
                samp_cnt_d = '0;
                bit_cnt_d  = '0;
                ferr_acc_d = 1'b0;
                if (prev_q && !sync2_q) begin
                    state_d = S_START;
                    div_d   = baud_div;
                    stop2_d = stop2;
`ifdef UART_RX_PARITY_EN
                    pmode_d = parity_mode;
`endif
                end
            end
            S_START: begin
                // A start bit that votes high was a glitch: drop it silently.
                if (w_resolve && w_maj) begin
                    state_d = S_IDLE;
                end else if (w_wrap) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (w_resolve) begin
                    shift_d = {w_maj, shift_q[DATA_W-1:1]};
                end
                if (w_wrap) begin
                    if (bit_cnt_q == C_BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = w_par_en ? S_PARITY : S_STOP;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + C_BIT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_resolve) begin
                    pbit_d = w_maj;
                end
                if (w_wrap) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_resolve) begin
                    if (!w_maj) begin
                        ferr_acc_d = 1'b1;
                    end
                    // Leave right after the last stop sample; the rest of
                    // the stop bit is spent in IDLE waiting for a new edge.
                    if (!stop2_q || bit_cnt_q == C_BIT_ONE) begin
                        state_d = S_DONE;
                    end
                end else if (w_wrap) begin
                    bit_cnt_d = bit_cnt_q + C_BIT_W'(1);
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                rx_valid_d = 1'b1;
                rx_data_d  = shift_q;
                perr_d     = w_perr;
                ferr_d     = ferr_acc_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            tick_cnt_q <= '0;
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            shift_q    <= '0;
            div_q      <= '0;
            stop2_q    <= 1'b0;
            ferr_acc_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pmode_q    <= 2'b00;
            pbit_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync1_q    <= rxd;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            tick_cnt_q <= tick_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            stop2_q    <= stop2_d;
            ferr_acc_q <= ferr_acc_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            pmode_q    <= pmode_d;
            pbit_q     <= pbit_d;
`endif
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_param
//  Description : Directed self-checking bench for uart_rx_param at 50 MHz,
//                OVS=16, baud_div=26 (one bit = 432 clk cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int BIT = 432;

    logic        clk;
    logic        rst_n;
    logic        rxd;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        parity_err;
    logic        frame_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Capture of every cycle rx_valid is high.
    int         vcnt = 0;
    logic [7:0] cap_data = 8'h00;
    logic       cap_perr = 1'b0;
    logic       cap_ferr = 1'b0;
    logic [7:0] log_q[$];

    uart_rx_param #(
        .DATA_W (8),
        .OVS    (16),
        .DIV_W  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            vcnt     = vcnt + 1;
            cap_data = rx_data;
            cap_perr = parity_err;
            cap_ferr = frame_err;
            log_q.push_back(rx_data);
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame on the line, followed by one idle bit time.
    task automatic send_frame(input logic [7:0] d, input bit use_par, input logic pbit,
                              input logic stop_val, input int nstop,
                              input int spike_bit, input bit disturb);
        logic [15:0] sv_div;
        logic [1:0]  sv_pm;
        logic        sv_s2;
        sv_div = baud_div;
        sv_pm  = parity_mode;
        sv_s2  = stop2;
        rxd = 1'b0;
        wait_clks(BIT);
        if (disturb) begin
            baud_div    = 16'd5;
            parity_mode = 2'b01;
            stop2       = ~stop2;
        end
        for (int i = 0; i < 8; i++) begin
            if (i == spike_bit) begin
                // Low for one tick period centred on sample tick 8.
                rxd = 1'b1; wait_clks(233);
                rxd = 1'b0; wait_clks(27);
                rxd = 1'b1; wait_clks(BIT - 260);
            end else begin
                rxd = d[i];
                wait_clks(BIT);
            end
        end
        if (use_par) begin
            rxd = pbit;
            wait_clks(BIT);
        end
        for (int s = 0; s < nstop; s++) begin
            rxd = stop_val;
            wait_clks(BIT);
        end
        rxd = 1'b1;
        if (disturb) begin
            baud_div    = sv_div;
            parity_mode = sv_pm;
            stop2       = sv_s2;
        end
        wait_clks(BIT);
    endtask

    initial begin
        int v0;
        rst_n       = 1'b0;
        rxd         = 1'b1;
        baud_div    = 16'd26;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        wait_clks(5);

        // Reset state
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        wait_clks(20);

        // 0xA5 8N1
        v0 = vcnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1, -1, 1'b0);
        check("a5_valid_count", 32'(vcnt - v0), 32'd1);
        check("a5_data", 32'(cap_data), 32'hA5);
        check("a5_parity_err", 32'(cap_perr), 32'h0);
        check("a5_frame_err", 32'(cap_ferr), 32'h0);
        check("a5_busy_after", 32'(busy), 32'h0);

        // False start: low for 3 ticks
        v0 = vcnt;
        rxd = 1'b0;
        wait_clks(81);
        check("false_busy_during", 32'(busy), 32'h1);
        rxd = 1'b1;
        wait_clks(BIT);
        check("false_valid_count", 32'(vcnt - v0), 32'd0);
        check("false_busy_after", 32'(busy), 32'h0);
        check("false_data_held", 32'(rx_data), 32'hA5);

        // Parity: even mode, 0x37 with wrong parity bit
        v0 = vcnt;
        parity_mode = 2'b10;
`ifdef UART_RX_PARITY_EN
        send_frame(8'h37, 1'b1, 1'b0, 1'b1, 1, -1, 1'b0);
        check("par_parity_err", 32'(cap_perr), 32'h1);
`else
        send_frame(8'h37, 1'b0, 1'b0, 1'b1, 1, -1, 1'b0);
        check("par_parity_err", 32'(cap_perr), 32'h0);
`endif
        check("par_valid_count", 32'(vcnt - v0), 32'd1);
        check("par_data", 32'(cap_data), 32'h37);
        parity_mode = 2'b00;

        // Stop bit 0 -> frame error, then clean frame (config disturbed mid-frame)
        v0 = vcnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1, -1, 1'b0);
        check("ferr_valid_count", 32'(vcnt - v0), 32'd1);
        check("ferr_data", 32'(cap_data), 32'h3C);
        check("ferr_frame_err", 32'(cap_ferr), 32'h1);
        v0 = vcnt;
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1, -1, 1'b1);
        check("next_valid_count", 32'(vcnt - v0), 32'd1);
        check("next_data", 32'(cap_data), 32'h81);
        check("next_frame_err", 32'(cap_ferr), 32'h0);

        // Single-tick spike inside data bit 3 of 0xFF
        v0 = vcnt;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1, 3, 1'b0);
        check("spike_valid_count", 32'(vcnt - v0), 32'd1);
        check("spike_data", 32'(cap_data), 32'hFF);
        check("spike_parity_err", 32'(cap_perr), 32'h0);
        check("spike_frame_err", 32'(cap_ferr), 32'h0);

        // Break: line low for 12 bit times
        v0 = vcnt;
        rxd = 1'b0;
        wait_clks(12 * BIT);
        rxd = 1'b1;
        wait_clks(BIT);
        check("break_valid_count", 32'(vcnt - v0), 32'd1);
        check("break_data", 32'(cap_data), 32'h00);
        check("break_frame_err", 32'(cap_ferr), 32'h1);

        // Reset after 4 data bits of 0x12 (LSB first: 0,1,0,0)
        v0 = vcnt;
        rxd = 1'b0; wait_clks(BIT);
        rxd = 1'b0; wait_clks(BIT);
        rxd = 1'b1; wait_clks(BIT);
        rxd = 1'b0; wait_clks(BIT);
        rxd = 1'b0; wait_clks(BIT);
        rxd = 1'b1;
        rst_n = 1'b0;
        wait_clks(3);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_frame_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        wait_clks(2 * BIT);
        check("midrst_valid_count", 32'(vcnt - v0), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1, -1, 1'b0);
        check("after_rst_valid_count", 32'(vcnt - v0), 32'd1);
        check("after_rst_data", 32'(cap_data), 32'h5A);

        // Two stop bits, back-to-back
        stop2 = 1'b1;
        v0 = vcnt;
        rxd = 1'b0; wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = (i == 0) ? 1'b1 : 1'b0;
            wait_clks(BIT);
        end
        rxd = 1'b1; wait_clks(2 * BIT);
        send_frame(8'h02, 1'b0, 1'b0, 1'b1, 2, -1, 1'b0);
        check("b2b_valid_count", 32'(vcnt - v0), 32'd2);
        if (log_q.size() >= 2) begin
            check("b2b_first", 32'(log_q[log_q.size() - 2]), 32'h01);
            check("b2b_second", 32'(log_q[log_q.size() - 1]), 32'h02);
        end else begin
            check("b2b_log_size", 32'(log_q.size()), 32'd2);
        end
        check("b2b_frame_err", 32'(cap_ferr), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
